// File: rtl/hood_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hood_pkg
// Description : Shared encodings for the range-hood mode scheduler: mode
//               states, fan level constants and button decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package hood_pkg;

  // Mode encoding; values are visible on the state output port.
  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_STANDBY    = 3'd1,
    ST_MENU       = 3'd2,
    ST_LEVEL1     = 3'd3,
    ST_LEVEL2     = 3'd4,
    ST_TURBO      = 3'd5,
    ST_TURBO_EXIT = 3'd6,
    ST_CLEAN      = 3'd7
  } hood_state_e;

  localparam logic [1:0] FAN_OFF   = 2'd0;
  localparam logic [1:0] FAN_L1    = 2'd1;
  localparam logic [1:0] FAN_L2    = 2'd2;
  localparam logic [1:0] FAN_TURBO = 2'd3;

  // Single winning button after priority resolution.
  typedef enum logic [2:0] {
    BTN_NONE  = 3'd0,
    BTN_MENU  = 3'd1,
    BTN_CLEAN = 3'd2,
    BTN_L3    = 3'd3,
    BTN_L2    = 3'd4,
    BTN_L1    = 3'd5
  } btn_e;

  // menu > clean > l3 > l2 > l1; lower-priority presses are dropped.
  function automatic btn_e decode_btn(input logic menu, input logic clean,
                                      input logic l3, input logic l2,
                                      input logic l1);
    if (menu)       return BTN_MENU;
    else if (clean) return BTN_CLEAN;
    else if (l3)    return BTN_L3;
    else if (l2)    return BTN_L2;
    else if (l1)    return BTN_L1;
    else            return BTN_NONE;
  endfunction

  function automatic logic [1:0] fan_for_state(input hood_state_e s);
    case (s)
      ST_LEVEL1:                return FAN_L1;
      ST_LEVEL2:                return FAN_L2;
      ST_TURBO, ST_TURBO_EXIT:  return FAN_TURBO;
      default:                  return FAN_OFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sec_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : sec_tick_gen
// Description : Divides clk down to a one-cycle pulse every CLK_HZ cycles.
//               restart zeroes the divider so a new period begins next cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sec_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int          CW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLK_HZ - 1);

  logic [CW-1:0] count;

  // Free-running divider, cleared on restart or when a period completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart || (count == TERMINAL)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == TERMINAL);

endmodule
`default_nettype wire

// File: rtl/hood_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hood_mode_scheduler
// Description : Range-hood mode sequencer. Resolves button pulses into one
//               active mode, drives fan level and cleaning enable, and runs
//               the per-mode second countdowns. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module hood_mode_scheduler
  import hood_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TURBO_SECS = 60,
  parameter int EXIT_SECS  = 60,
  parameter int CLEAN_SECS = 180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_on,
  input  logic       btn_menu,
  input  logic       btn_l1,
  input  logic       btn_l2,
  input  logic       btn_l3,
  input  logic       btn_clean,
  input  logic       clean_done,
  output logic [2:0] state,
  output logic [1:0] fan_level,
  output logic       clean_sel,
  output logic [7:0] remaining,
  output logic       turbo_used,
  output logic       alert
);

  hood_state_e state_q, state_d;
  logic [7:0]  remaining_d;
  logic        turbo_used_d;
  logic        alert_d;
  logic        tick;
  logic        restart;
  logic        expiry;
  logic        any_btn;
  btn_e        btn;

  // Any state change restarts the second divider so the first decrement
  // lands exactly one full second after entering a timed mode.
  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  function automatic logic [7:0] load_count(input hood_state_e s);
    case (s)
      ST_TURBO:      return 8'(TURBO_SECS);
      ST_TURBO_EXIT: return 8'(EXIT_SECS);
      ST_CLEAN:      return 8'(CLEAN_SECS);
      default:       return 8'd0;
    endcase
  endfunction

  assign btn     = decode_btn(btn_menu, btn_clean, btn_l3, btn_l2, btn_l1);
  assign any_btn = btn_menu | btn_clean | btn_l3 | btn_l2 | btn_l1;
  assign expiry  = tick && (remaining == 8'd1);
  assign restart = (state_d != state_q);

  // Next-mode, countdown, turbo latch and alert decisions.
  always_comb begin
    state_d      = state_q;
    turbo_used_d = turbo_used;
    alert_d      = alert;
    remaining_d  = remaining;

    if (!power_on) begin
      state_d      = ST_OFF;
      turbo_used_d = 1'b0;
      alert_d      = 1'b0;
    end else begin
      if (any_btn) alert_d = 1'b0;
      case (state_q)
        ST_OFF:     state_d = ST_STANDBY;
        ST_STANDBY: if (btn == BTN_MENU) state_d = ST_MENU;
        ST_MENU: begin
          case (btn)
            BTN_MENU:  state_d = ST_STANDBY;
            BTN_L1:    state_d = ST_LEVEL1;
            BTN_L2:    state_d = ST_LEVEL2;
            BTN_CLEAN: state_d = ST_CLEAN;
            BTN_L3: begin
              if (!turbo_used) begin
                state_d      = ST_TURBO;
                turbo_used_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
        ST_LEVEL1: begin
          if (btn == BTN_MENU)    state_d = ST_STANDBY;
          else if (btn == BTN_L2) state_d = ST_LEVEL2;
        end
        ST_LEVEL2: begin
          if (btn == BTN_MENU)    state_d = ST_STANDBY;
          else if (btn == BTN_L1) state_d = ST_LEVEL1;
        end
        ST_TURBO: begin
          // A menu press in the expiry cycle still takes the exit path.
          if (btn == BTN_MENU) state_d = ST_TURBO_EXIT;
          else if (expiry)     state_d = ST_LEVEL2;
        end
        ST_TURBO_EXIT: if (expiry) state_d = ST_STANDBY;
        ST_CLEAN: begin
          if (clean_done || expiry) begin
            state_d = ST_STANDBY;
            alert_d = 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    if (state_d != state_q) begin
      remaining_d = load_count(state_d);
    end else if (tick && (remaining != 8'd0)) begin
      remaining_d = remaining - 8'd1;
    end
  end

  // Output and state registers; outputs are derived from the next state so
  // they change on the same edge as the mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      fan_level  <= FAN_OFF;
      clean_sel  <= 1'b0;
      remaining  <= 8'd0;
      turbo_used <= 1'b0;
      alert      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fan_level  <= fan_for_state(state_d);
      clean_sel  <= (state_d == ST_CLEAN);
      remaining  <= remaining_d;
      turbo_used <= turbo_used_d;
      alert      <= alert_d;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_hood_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_hood_mode_scheduler
// Description : Self-checking bench for hood_mode_scheduler with CLK_HZ = 10.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hood_mode_scheduler;
  import hood_pkg::*;

  localparam logic [5:0] B_NONE  = 6'b000000;
  localparam logic [5:0] B_MENU  = 6'b100000;
  localparam logic [5:0] B_CLEAN = 6'b010000;
  localparam logic [5:0] B_L3    = 6'b001000;
  localparam logic [5:0] B_L2    = 6'b000100;
  localparam logic [5:0] B_L1    = 6'b000010;
  localparam logic [5:0] B_DONE  = 6'b000001;

  typedef struct {
    logic       po;
    logic [5:0] btn;
    logic [2:0] s;
    logic [1:0] f;
    logic       cs;
    logic [7:0] r;
    logic       tu;
    logic       al;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       power_on = 1'b0;
  logic       btn_menu = 1'b0, btn_l1 = 1'b0, btn_l2 = 1'b0, btn_l3 = 1'b0;
  logic       btn_clean = 1'b0, clean_done = 1'b0;
  logic [2:0] state;
  logic [1:0] fan_level;
  logic       clean_sel;
  logic [7:0] remaining;
  logic       turbo_used;
  logic       alert;

  int errors = 0;
  int checks = 0;
  vec_t vecs[20];

  always #5 clk = ~clk;

  hood_mode_scheduler #(
    .CLK_HZ(10), .TURBO_SECS(60), .EXIT_SECS(60), .CLEAN_SECS(180)
  ) dut (
    .clk(clk), .rst_n(rst_n), .power_on(power_on),
    .btn_menu(btn_menu), .btn_l1(btn_l1), .btn_l2(btn_l2), .btn_l3(btn_l3),
    .btn_clean(btn_clean), .clean_done(clean_done),
    .state(state), .fan_level(fan_level), .clean_sel(clean_sel),
    .remaining(remaining), .turbo_used(turbo_used), .alert(alert)
  );

  function automatic vec_t mk(input logic po, input logic [5:0] b,
                              input hood_state_e s, input logic [1:0] f,
                              input logic cs, input logic [7:0] r,
                              input logic tu, input logic al);
    vec_t v;
    v.po = po; v.btn = b; v.s = s; v.f = f;
    v.cs = cs; v.r = r; v.tu = tu; v.al = al;
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [5:0] b);
    {btn_menu, btn_clean, btn_l3, btn_l2, btn_l1, clean_done} = b;
    cyc(1);
    {btn_menu, btn_clean, btn_l3, btn_l2, btn_l1, clean_done} = B_NONE;
  endtask

  task automatic check(input string name, input hood_state_e s,
                       input logic [1:0] f, input logic cs,
                       input logic [7:0] r, input logic tu, input logic al);
    checks++;
    if ({state, fan_level, clean_sel, remaining, turbo_used, alert} !==
        {s, f, cs, r, tu, al}) begin
      errors++;
      $display("FAIL %s: got state=%0d fan=%0d clean_sel=%0b rem=%0d tu=%0b alert=%0b, want state=%0d fan=%0d clean_sel=%0b rem=%0d tu=%0b alert=%0b",
               name, state, fan_level, clean_sel, remaining, turbo_used, alert,
               s, f, cs, r, tu, al);
    end
  endtask

  // Directed stimulus: vector table, then multi-cycle timing sequences.
  initial begin
    vecs[0]  = mk(1, B_NONE,        ST_STANDBY,    0, 0, 0,   0, 0);
    vecs[1]  = mk(1, B_MENU,        ST_MENU,       0, 0, 0,   0, 0);
    vecs[2]  = mk(1, B_L1,          ST_LEVEL1,     1, 0, 0,   0, 0);
    vecs[3]  = mk(1, B_L2,          ST_LEVEL2,     2, 0, 0,   0, 0);
    vecs[4]  = mk(1, B_L3,          ST_LEVEL2,     2, 0, 0,   0, 0);
    vecs[5]  = mk(1, B_CLEAN,       ST_LEVEL2,     2, 0, 0,   0, 0);
    vecs[6]  = mk(1, B_L1,          ST_LEVEL1,     1, 0, 0,   0, 0);
    vecs[7]  = mk(1, B_MENU,        ST_STANDBY,    0, 0, 0,   0, 0);
    vecs[8]  = mk(1, B_L1,          ST_STANDBY,    0, 0, 0,   0, 0);
    vecs[9]  = mk(1, B_MENU,        ST_MENU,       0, 0, 0,   0, 0);
    vecs[10] = mk(1, B_MENU | B_L1, ST_STANDBY,    0, 0, 0,   0, 0);
    vecs[11] = mk(1, B_MENU,        ST_MENU,       0, 0, 0,   0, 0);
    vecs[12] = mk(1, B_L3 | B_L2,   ST_TURBO,      3, 0, 60,  1, 0);
    vecs[13] = mk(0, B_NONE,        ST_OFF,        0, 0, 0,   0, 0);
    vecs[14] = mk(1, B_NONE,        ST_STANDBY,    0, 0, 0,   0, 0);
    vecs[15] = mk(1, B_MENU,        ST_MENU,       0, 0, 0,   0, 0);
    vecs[16] = mk(1, B_CLEAN | B_L3, ST_CLEAN,     0, 1, 180, 0, 0);
    vecs[17] = mk(1, B_MENU,        ST_CLEAN,      0, 1, 180, 0, 0);
    vecs[18] = mk(1, B_DONE,        ST_STANDBY,    0, 0, 0,   0, 1);
    vecs[19] = mk(1, B_L1,          ST_STANDBY,    0, 0, 0,   0, 0);

    // Reset state
    power_on = 1'b1;
    cyc(2);
    check("reset", ST_OFF, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 20; i++) begin
      power_on = vecs[i].po;
      press(vecs[i].btn);
      check($sformatf("vec%0d", i), hood_state_e'(vecs[i].s), vecs[i].f,
            vecs[i].cs, vecs[i].r, vecs[i].tu, vecs[i].al);
    end

    // Turbo countdown and natural expiry to LEVEL2
    press(B_MENU);  check("t_menu", ST_MENU, 0, 0, 0, 0, 0);
    press(B_L3);    check("t_entry", ST_TURBO, 3, 0, 60, 1, 0);
    cyc(9);         check("t_9clk", ST_TURBO, 3, 0, 60, 1, 0);
    cyc(1);         check("t_10clk", ST_TURBO, 3, 0, 59, 1, 0);
    cyc(589);       check("t_599clk", ST_TURBO, 3, 0, 1, 1, 0);
    cyc(1);         check("t_expire", ST_LEVEL2, 2, 0, 0, 1, 0);

    // Turbo refused once used
    press(B_MENU);  check("ru_stby", ST_STANDBY, 0, 0, 0, 1, 0);
    press(B_MENU);  check("ru_menu", ST_MENU, 0, 0, 0, 1, 0);
    press(B_L3);    check("ru_l3_refused", ST_MENU, 0, 0, 0, 1, 0);

    // Power cycle re-arms turbo; cancel at 40 s into TURBO_EXIT
    power_on = 1'b0; cyc(1); check("pc_off", ST_OFF, 0, 0, 0, 0, 0);
    power_on = 1'b1; cyc(1); check("pc_on", ST_STANDBY, 0, 0, 0, 0, 0);
    press(B_MENU);
    press(B_L3);    check("x_entry", ST_TURBO, 3, 0, 60, 1, 0);
    cyc(200);       check("x_rem40", ST_TURBO, 3, 0, 40, 1, 0);
    press(B_MENU);  check("x_exit", ST_TURBO_EXIT, 3, 0, 60, 1, 0);
    press(B_L1);    check("x_ign_l1", ST_TURBO_EXIT, 3, 0, 60, 1, 0);
    press(B_CLEAN); check("x_ign_cl", ST_TURBO_EXIT, 3, 0, 60, 1, 0);
    press(B_MENU);  check("x_ign_menu", ST_TURBO_EXIT, 3, 0, 60, 1, 0);
    cyc(596);       check("x_599clk", ST_TURBO_EXIT, 3, 0, 1, 1, 0);
    cyc(1);         check("x_expire", ST_STANDBY, 0, 0, 0, 1, 0);

    // Menu in the same cycle as turbo expiry wins
    power_on = 1'b0; cyc(1);
    power_on = 1'b1; cyc(1);
    press(B_MENU);
    press(B_L3);
    cyc(599);       check("me_rem1", ST_TURBO, 3, 0, 1, 1, 0);
    press(B_MENU);  check("me_menu_wins", ST_TURBO_EXIT, 3, 0, 60, 1, 0);
    cyc(600);       check("me_done", ST_STANDBY, 0, 0, 0, 1, 0);

    // Clean finished by clean_done at 50 s remaining
    press(B_MENU);
    press(B_CLEAN); check("c_entry", ST_CLEAN, 0, 1, 180, 1, 0);
    cyc(1300);      check("c_rem50", ST_CLEAN, 0, 1, 50, 1, 0);
    press(B_DONE);  check("c_done", ST_STANDBY, 0, 0, 0, 1, 1);
    press(B_MENU);  check("c_alert_clr", ST_MENU, 0, 0, 0, 1, 0);

    // Clean timeout, with clean_done landing on the expiry edge
    press(B_CLEAN); check("ct_entry", ST_CLEAN, 0, 1, 180, 1, 0);
    cyc(1799);      check("ct_rem1", ST_CLEAN, 0, 1, 1, 1, 0);
    press(B_DONE);  check("ct_expire", ST_STANDBY, 0, 0, 0, 1, 1);

    // Asynchronous reset in the middle of CLEAN
    press(B_MENU);  check("ar_menu", ST_MENU, 0, 0, 0, 1, 0);
    press(B_CLEAN);
    cyc(5);         check("ar_clean", ST_CLEAN, 0, 1, 180, 1, 0);
    #2 rst_n = 1'b0;
    #1 check("ar_async", ST_OFF, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);         check("ar_recover", ST_STANDBY, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
